// File: rtl/sc_spi_pkg.sv
// Shared types and widths for the SPI transfer sequencer slice.
//   - xfer_state_e : sequencer states
//   - xfer_cmd_t   : command payload latched at accept and driven to the engine
//   - words_max()  : running RX word count update
package sc_spi_pkg;

    localparam int unsigned DWIDTH_W = 9;
    localparam int unsigned PTR_W    = 4;
    localparam int unsigned CSSEL_W  = 5;
    localparam int unsigned DATA_W   = 32;
    // Holds the RX word count 0..16, one bit wider than a pointer.
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAITB = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } xfer_state_e;

    typedef struct packed {
        logic [DWIDTH_W-1:0] dwidth;
        logic [CSSEL_W-1:0]  cssel;
        logic                csext;
    } xfer_cmd_t;

    // Word count after capturing index dpt: max(cur, dpt+1).
    function automatic logic [CNT_W-1:0] words_max(input logic [CNT_W-1:0] cur,
                                                   input logic [PTR_W-1:0] dpt);
        logic [CNT_W-1:0] nxt;
        nxt = CNT_W'(dpt) + CNT_W'(1);
        return (nxt > cur) ? nxt : cur;
    endfunction

endpackage

// File: rtl/sc_spi_wbuf.sv
// Word buffer: DEPTH x DATA_W register file, one synchronous write port,
// one combinational read port, asynchronous clear.
//   SPICLK, SYSRSTB : clock, async active-low clear of all words
//   we_i/waddr_i/wdata_i : write port; addresses >= DEPTH are ignored
//   raddr_i/rdata_o      : read port; addresses >= DEPTH read as zero
module sc_spi_wbuf
    import sc_spi_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              SPICLK,
    input  logic              SYSRSTB,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned NUM_SLOTS = 2 ** PTR_W;
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

    // Storage spans the full pointer range; slots at or above DEPTH are never
    // written and stay zero.
    logic [DATA_W-1:0] mem_q [NUM_SLOTS];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = we_i && ({1'b0, waddr_i} < DEPTH_L);
    assign rd_ok = {1'b0, raddr_i} < DEPTH_L;

    // Write port with async clear
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            mem_q <= '{default: '0};
        end else if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rd_ok ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/sc_spi_xfer_ctrl.sv
// Transfer sequencer and word buffer upstream of the SPI protocol engine.
// Accepts one host command, serves TX words by engine pointer, pulses
// SPISTART, captures RX words and reports completion.
//   Host    : CMD_VALID/READY/DWIDTH/CSSEL/CSEXT, TXWE/TXWADDR/TXWDATA,
//             RXRADDR/RXRDATA (1-cycle read), XFER_BUSY/DONE/ERR, RXWORDS
//   Engine  : DWIDTH/CSSEL/CSEXTEND/SPISTART out, SPIBUSY in,
//             TXDPT in / TXDATA out (combinational), RXDATA/RXVALID/RXDPT in
//   SPICLK clock, SYSRSTB async active-low reset
module sc_spi_xfer_ctrl
    import sc_spi_pkg::*;
#(
    parameter int unsigned BUF_WORDS = 16,
    parameter int unsigned START_TO  = 8
) (
    input  logic                SPICLK,
    input  logic                SYSRSTB,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [DWIDTH_W-1:0] CMD_DWIDTH,
    input  logic [CSSEL_W-1:0]  CMD_CSSEL,
    input  logic                CMD_CSEXT,
    input  logic                TXWE,
    input  logic [PTR_W-1:0]    TXWADDR,
    input  logic [DATA_W-1:0]   TXWDATA,
    input  logic [PTR_W-1:0]    RXRADDR,
    output logic [DATA_W-1:0]   RXRDATA,
    output logic                XFER_BUSY,
    output logic                XFER_DONE,
    output logic                XFER_ERR,
    output logic [CNT_W-1:0]    RXWORDS,
    output logic [DWIDTH_W-1:0] DWIDTH,
    output logic [CSSEL_W-1:0]  CSSEL,
    output logic                CSEXTEND,
    output logic                SPISTART,
    input  logic                SPIBUSY,
    input  logic [PTR_W-1:0]    TXDPT,
    output logic [DATA_W-1:0]   TXDATA,
    input  logic [DATA_W-1:0]   RXDATA,
    input  logic                RXVALID,
    input  logic [PTR_W-1:0]    RXDPT
);

    localparam int unsigned   TO_W    = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] BUF_WORDS_L = CNT_W'(BUF_WORDS);

    xfer_state_e       state_q;
    xfer_cmd_t         cmd_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              start_q;
    logic [CNT_W-1:0]  rxwords_q;
    logic [CNT_W-1:0]  rxwords_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [DATA_W-1:0] rxrdata_q;
    logic [DATA_W-1:0] rx_rdata;

    logic tx_we;
    logic tx_drop;
    logic rx_we;

    // Host TX writes land only while idle; a write during a transfer is lost
    // and flagged.
    assign tx_we   = TXWE && !busy_q;
    assign tx_drop = TXWE && busy_q;

    // RX capture is independent of state so a late final word is kept.
    assign rx_we     = RXVALID && ({1'b0, RXDPT} < BUF_WORDS_L);
    assign rxwords_d = rx_we ? words_max(rxwords_q, RXDPT) : rxwords_q;

    sc_spi_wbuf #(
        .DEPTH (BUF_WORDS)
    ) u_txbuf (
        .SPICLK  (SPICLK),
        .SYSRSTB (SYSRSTB),
        .we_i    (tx_we),
        .waddr_i (TXWADDR),
        .wdata_i (TXWDATA),
        .raddr_i (TXDPT),
        .rdata_o (TXDATA)
    );

    sc_spi_wbuf #(
        .DEPTH (BUF_WORDS)
    ) u_rxbuf (
        .SPICLK  (SPICLK),
        .SYSRSTB (SYSRSTB),
        .we_i    (rx_we),
        .waddr_i (RXDPT),
        .wdata_i (RXDATA),
        .raddr_i (RXRADDR),
        .rdata_o (rx_rdata)
    );

    // Host RX read register; a same-cycle capture is seen one read later.
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            rxrdata_q <= '0;
        end else begin
            rxrdata_q <= rx_rdata;
        end
    end

    // Sequencer with registered handshake and engine outputs
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            rxwords_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            rxwords_q <= rxwords_d;
            if (tx_drop) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (CMD_VALID && ready_q) begin
                        cmd_q     <= '{dwidth: CMD_DWIDTH, cssel: CMD_CSSEL, csext: CMD_CSEXT};
                        rxwords_q <= '0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        start_q   <= 1'b1;
                        state_q   <= ST_START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    to_cnt_q <= '0;
                    state_q  <= ST_WAITB;
                end
                ST_WAITB: begin
                    // Engine acknowledge wins over a timeout in the same cycle.
                    if (SPIBUSY) begin
                        state_q <= ST_RUN;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!SPIBUSY) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = ready_q;
    assign XFER_BUSY = busy_q;
    assign XFER_DONE = done_q;
    assign XFER_ERR  = err_q;
    assign RXWORDS   = rxwords_q;
    assign DWIDTH    = cmd_q.dwidth;
    assign CSSEL     = cmd_q.cssel;
    assign CSEXTEND  = cmd_q.csext;
    assign SPISTART  = start_q;
    assign RXRDATA   = rxrdata_q;

endmodule

// File: tb/tb_sc_spi_xfer_ctrl.sv
// Self-checking bench for sc_spi_xfer_ctrl: directed scenarios plus randomized
// transfers against a word-level reference model (TX/RX arrays, word count, error).
module tb_sc_spi_xfer_ctrl;

    localparam int unsigned BUF_WORDS = 16;
    localparam int unsigned START_TO  = 8;

    logic        SPICLK;
    logic        SYSRSTB;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [8:0]  CMD_DWIDTH;
    logic [4:0]  CMD_CSSEL;
    logic        CMD_CSEXT;
    logic        TXWE;
    logic [3:0]  TXWADDR;
    logic [31:0] TXWDATA;
    logic [3:0]  RXRADDR;
    logic [31:0] RXRDATA;
    logic        XFER_BUSY;
    logic        XFER_DONE;
    logic        XFER_ERR;
    logic [4:0]  RXWORDS;
    logic [8:0]  DWIDTH;
    logic [4:0]  CSSEL;
    logic        CSEXTEND;
    logic        SPISTART;
    logic        SPIBUSY;
    logic [3:0]  TXDPT;
    logic [31:0] TXDATA;
    logic [31:0] RXDATA;
    logic        RXVALID;
    logic [3:0]  RXDPT;

    sc_spi_xfer_ctrl #(
        .BUF_WORDS (BUF_WORDS),
        .START_TO  (START_TO)
    ) dut (
        .SPICLK     (SPICLK),
        .SYSRSTB    (SYSRSTB),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_DWIDTH (CMD_DWIDTH),
        .CMD_CSSEL  (CMD_CSSEL),
        .CMD_CSEXT  (CMD_CSEXT),
        .TXWE       (TXWE),
        .TXWADDR    (TXWADDR),
        .TXWDATA    (TXWDATA),
        .RXRADDR    (RXRADDR),
        .RXRDATA    (RXRDATA),
        .XFER_BUSY  (XFER_BUSY),
        .XFER_DONE  (XFER_DONE),
        .XFER_ERR   (XFER_ERR),
        .RXWORDS    (RXWORDS),
        .DWIDTH     (DWIDTH),
        .CSSEL      (CSSEL),
        .CSEXTEND   (CSEXTEND),
        .SPISTART   (SPISTART),
        .SPIBUSY    (SPIBUSY),
        .TXDPT      (TXDPT),
        .TXDATA     (TXDATA),
        .RXDATA     (RXDATA),
        .RXVALID    (RXVALID),
        .RXDPT      (RXDPT)
    );

    initial SPICLK = 1'b0;
    always #5 SPICLK = ~SPICLK;

    int n_chk;
    int n_fail;

    // Reference model state
    logic [31:0] m_tx [BUF_WORDS];
    logic [31:0] m_rx [BUF_WORDS];
    int          m_rxw;
    int          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SPICLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < BUF_WORDS; i++) begin
            m_tx[i] = '0;
            m_rx[i] = '0;
        end
        m_rxw = 0;
        m_err = 0;
    endtask

    // Idle-time TX write
    task automatic wr_tx(input int a, input logic [31:0] d);
        TXWE    = 1'b1;
        TXWADDR = 4'(a);
        TXWDATA = d;
        tick();
        TXWE = 1'b0;
        if (a < BUF_WORDS) m_tx[a] = d;
    endtask

    // Engine delivering a stray RX word outside a transfer
    task automatic inject_rx(input int dpt, input logic [31:0] d);
        RXVALID = 1'b1;
        RXDPT   = 4'(dpt);
        RXDATA  = d;
        tick();
        RXVALID = 1'b0;
        m_rx[dpt] = d;
        if (dpt + 1 > m_rxw) m_rxw = dpt + 1;
        chk("late_rxwords", 32'(RXWORDS), m_rxw);
    endtask

    // Full sweep of both buffers against the model
    task automatic check_bufs(input string tag);
        for (int a = 0; a < BUF_WORDS; a++) begin
            TXDPT = 4'(a);
            #1;
            chk($sformatf("%s_txdata%0d", tag, a), TXDATA, m_tx[a]);
            RXRADDR = 4'(a);
            tick();
            chk($sformatf("%s_rxrdata%0d", tag, a), RXRDATA, m_rx[a]);
        end
    endtask

    // One command: bdly = cycles before engine raises SPIBUSY (>= START_TO: never)
    task automatic run_xfer(input logic [8:0] dw, input logic [4:0] cs, input bit ext,
                            input int bdly, input bit loopb, input bit wr_run,
                            input bit hold, input bit immed);
        int          waits;
        int          nw;
        int          a;
        logic [31:0] v;
        logic [31:0] old;
        CMD_VALID  = 1'b1;
        CMD_DWIDTH = dw;
        CMD_CSSEL  = cs;
        CMD_CSEXT  = ext;
        waits = 0;
        while (CMD_READY !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        if (immed) chk("accept_wait", waits, 0);
        if (CMD_READY !== 1'b1) begin
            chk("ready_timeout", 32'(CMD_READY), 1);
            CMD_VALID = 1'b0;
            return;
        end
        tick();
        if (!hold) CMD_VALID = 1'b0;
        m_err = 0;
        m_rxw = 0;
        chk("start_pulse",   32'(SPISTART), 1);
        chk("start_busy",    32'(XFER_BUSY), 1);
        chk("start_ready",   32'(CMD_READY), 0);
        chk("start_err_clr", 32'(XFER_ERR), 0);
        chk("start_rxw_clr", 32'(RXWORDS), 0);
        chk("start_dwidth",  32'(DWIDTH), 32'(dw));
        chk("start_cssel",   32'(CSSEL), 32'(cs));
        chk("start_csext",   32'(CSEXTEND), 32'(ext));
        tick();
        chk("start_one_cycle", 32'(SPISTART), 0);
        if (bdly >= START_TO) begin
            repeat (START_TO - 1) tick();
            chk("to_done_early", 32'(XFER_DONE), 0);
            tick();
            m_err = 1;
            chk("to_done", 32'(XFER_DONE), 1);
        end else begin
            repeat (bdly) tick();
            SPIBUSY = 1'b1;
            tick();
            nw = int'(dw[8:5]) + 1;
            for (int w = 0; w < nw; w++) begin
                TXDPT = 4'(w);
                #1;
                chk("run_txdata", TXDATA, m_tx[w]);
                v   = loopb ? m_tx[w] : $urandom;
                old = m_rx[w];
                RXVALID = 1'b1;
                RXDPT   = 4'(w);
                RXDATA  = v;
                RXRADDR = 4'(w);
                tick();
                RXVALID = 1'b0;
                chk("rd_old_on_capture", RXRDATA, old);
                m_rx[w] = v;
                if (w + 1 > m_rxw) m_rxw = w + 1;
                chk("run_rxwords", 32'(RXWORDS), m_rxw);
            end
            if (wr_run) begin
                a = int'($urandom_range(0, BUF_WORDS - 1));
                TXWE    = 1'b1;
                TXWADDR = 4'(a);
                TXWDATA = $urandom;
                tick();
                TXWE  = 1'b0;
                m_err = 1;
                chk("drop_err", 32'(XFER_ERR), 1);
                TXDPT = 4'(a);
                #1;
                chk("drop_txkept", TXDATA, m_tx[a]);
            end
            chk("run_no_done", 32'(XFER_DONE), 0);
            SPIBUSY = 1'b0;
            tick();
            chk("run_done", 32'(XFER_DONE), 1);
        end
        chk("done_rxwords", 32'(RXWORDS), m_rxw);
        chk("done_err",     32'(XFER_ERR), m_err);
        chk("done_ready",   32'(CMD_READY), 0);
        tick();
        chk("idle_done_pulse", 32'(XFER_DONE), 0);
        chk("idle_ready",      32'(CMD_READY), 1);
        chk("idle_busy",       32'(XFER_BUSY), 0);
        chk("idle_err",        32'(XFER_ERR), m_err);
        chk("idle_dwidth",     32'(DWIDTH), 32'(dw));
        chk("idle_cssel",      32'(CSSEL), 32'(cs));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bd_to;
        n_chk = 0;
        n_fail = 0;
        model_clear();
        SYSRSTB = 1'b0;
        CMD_VALID = 1'b0;
        CMD_DWIDTH = '0;
        CMD_CSSEL = '0;
        CMD_CSEXT = 1'b0;
        TXWE = 1'b0;
        TXWADDR = '0;
        TXWDATA = '0;
        RXRADDR = '0;
        SPIBUSY = 1'b0;
        TXDPT = '0;
        RXDATA = '0;
        RXVALID = 1'b0;
        RXDPT = '0;

        // Reset state
        #12;
        chk("rst_ready",    32'(CMD_READY), 0);
        chk("rst_busy",     32'(XFER_BUSY), 0);
        chk("rst_done",     32'(XFER_DONE), 0);
        chk("rst_err",      32'(XFER_ERR), 0);
        chk("rst_rxwords",  32'(RXWORDS), 0);
        chk("rst_spistart", 32'(SPISTART), 0);
        chk("rst_rxrdata",  RXRDATA, 0);
        chk("rst_txdata",   TXDATA, 0);
        #11;
        SYSRSTB = 1'b1;
        tick();
        chk("rel_ready", 32'(CMD_READY), 1);

        // Single word
        wr_tx(0, 32'hA5A5_1234);
        run_xfer(9'd31, 5'd3, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("one_rxwords", 32'(RXWORDS), 1);
        check_bufs("one");
        inject_rx(3, 32'hDEAD_BEEF);
        check_bufs("late");

        // Full 16-word loopback
        for (int i = 0; i < BUF_WORDS; i++) wr_tx(i, $urandom);
        run_xfer(9'd511, 5'd17, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_rxwords", 32'(RXWORDS), 16);
        check_bufs("full");

        // Engine never answers
        run_xfer(9'd31, 5'd1, 1'b0, START_TO, 1'b0, 1'b0, 1'b0, 1'b0);

        // Dropped write while running, then back-to-back accept with VALID held
        run_xfer(9'd95, 5'd2, 1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b0);
        run_xfer(9'd63, 5'd9, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_xfer(9'd40, 5'd30, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        check_bufs("b2b");

        // Randomized transfers
        for (int it = 0; it < 20; it++) begin
            int nwr;
            nwr = int'($urandom_range(0, 6));
            for (int k = 0; k < nwr; k++) wr_tx(int'($urandom_range(0, BUF_WORDS - 1)), $urandom);
            bd_to = ($urandom_range(0, 99) < 15);
            run_xfer(9'($urandom_range(0, 511)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     bd_to ? START_TO : int'($urandom_range(0, START_TO - 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) && !bd_to,
                     1'b0, 1'b0);
            check_bufs("rnd");
        end

        // Reset while running
        wr_tx(7, 32'h1357_9BDF);
        CMD_VALID  = 1'b1;
        CMD_DWIDTH = 9'd127;
        CMD_CSSEL  = 5'd5;
        CMD_CSEXT  = 1'b1;
        tick();
        tick();
        CMD_VALID = 1'b0;
        tick();
        SPIBUSY = 1'b1;
        tick();
        tick();
        RXVALID = 1'b1;
        RXDPT   = 4'd2;
        RXDATA  = 32'hCAFE_F00D;
        tick();
        RXVALID = 1'b0;
        RXRADDR = 4'd2;
        TXDPT   = 4'd7;
        tick();
        chk("pre_rst_busy", 32'(XFER_BUSY), 1);
        chk("pre_rst_rd",   RXRDATA, 32'hCAFE_F00D);
        #3;
        SYSRSTB = 1'b0;
        #1;
        chk("mid_rst_busy",     32'(XFER_BUSY), 0);
        chk("mid_rst_ready",    32'(CMD_READY), 0);
        chk("mid_rst_rxwords",  32'(RXWORDS), 0);
        chk("mid_rst_dwidth",   32'(DWIDTH), 0);
        chk("mid_rst_cssel",    32'(CSSEL), 0);
        chk("mid_rst_csext",    32'(CSEXTEND), 0);
        chk("mid_rst_spistart", 32'(SPISTART), 0);
        chk("mid_rst_rxrdata",  RXRDATA, 0);
        chk("mid_rst_txdata",   TXDATA, 0);
        SPIBUSY = 1'b0;
        model_clear();
        tick();
        tick();
        #3;
        SYSRSTB = 1'b1;
        tick();
        chk("post_rst_ready", 32'(CMD_READY), 1);
        check_bufs("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
